// File: rtl/unary_multi_adder.sv
// unary_multi_adder: merges N_IN unary input bursts into a single unary output burst whose
// length is the total number of input ones, optionally clamped to U_BITS.
module unary_multi_adder #(
    parameter int unsigned  N_IN   = 4,
    parameter int unsigned  U_BITS = 16,
    parameter bit           SAT_EN = 1'b0,
    localparam int unsigned CNT_W  = $clog2(N_IN * U_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  in,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             saturated
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StSat  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] UMax   = CNT_W'(U_BITS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    logic [CNT_W-1:0] pop;
    logic             any_in;
    logic             out_c;
    logic             done_c;
    // pending + pop - out with one spare bit so an over-long burst is detectable
    logic [CNT_W:0]   acc;
    logic [CNT_W-1:0] count_inc;
    logic             sat_hit;

    // Number of channels carrying a one this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pop = pop + CNT_W'(in[i]);
        end
    end

    assign any_in = |in;

    // Next-state, pending/count bookkeeping and the combinational out/done strobes.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        sat_d     = sat_q;
        out_c     = 1'b0;
        done_c    = 1'b0;
        acc       = '0;
        count_inc = '0;
        sat_hit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                out_c = any_in;
                if (any_in) begin
                    // This cycle emits the first one; the rest of pop is owed.
                    state_d   = StRun;
                    pending_d = pop - CntOne;
                    count_d   = CntOne;
                    sat_d     = 1'b0;
                    if (SAT_EN && (UMax == CntOne)) begin
                        state_d   = StSat;
                        pending_d = '0;
                        sat_d     = (pop != CntOne);
                    end
                end
            end

            StRun: begin
                out_c = any_in | (pending_q != '0);
                acc   = {1'b0, pending_q} + {1'b0, pop} - {{CNT_W{1'b0}}, out_c};
                if (acc > {1'b0, CntMax}) begin
                    // Protocol violation: clamp and flag the loss.
                    pending_d = CntMax;
                    sat_d     = 1'b1;
                end else begin
                    pending_d = acc[CNT_W-1:0];
                end

                if (out_c) begin
                    count_inc = (count_q == CntMax) ? CntMax : count_q + CntOne;
                    count_d   = count_inc;
                    sat_hit   = SAT_EN && (count_inc == UMax);
                    if (sat_hit) begin
                        // Clamp reached: anything still owed is discarded.
                        state_d   = StSat;
                        pending_d = '0;
                        if (acc != '0) begin
                            sat_d = 1'b1;
                        end
                    end
                end else begin
                    done_c  = 1'b1;
                    state_d = StIdle;
                end
            end

            StSat: begin
                // Swallow the tail of the input bursts until all channels go quiet.
                if (any_in) begin
                    sat_d = 1'b1;
                end else begin
                    done_c  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    // out and done are zero-latency, so they are masked while reset is held.
    assign out       = out_c & ~reset;
    assign done      = done_c & ~reset;
    assign busy      = (state_q != StIdle);
    assign count     = count_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_unary_multi_adder.sv
// Bench for unary_multi_adder: one instance without and one with output saturation share
// the same stimulus; expected results are queued per operation and checked on done.
module tb_unary_multi_adder;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned U_BITS = 16;
    localparam int unsigned CNT_W  = $clog2(N_IN * U_BITS + 1);
    localparam int unsigned N_RAND = 40;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        int unsigned sat;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [N_IN-1:0]  in_v;
    logic             out0, busy0, done0, sat0;
    logic             out1, busy1, done1, sat1;
    logic [CNT_W-1:0] count0, count1;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned ones0 = 0;
    int unsigned ones1 = 0;
    int unsigned op_s[N_IN];
    int unsigned op_l[N_IN];

    unary_multi_adder #(.N_IN(N_IN), .U_BITS(U_BITS), .SAT_EN(1'b0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .in        (in_v),
        .out       (out0),
        .busy      (busy0),
        .done      (done0),
        .count     (count0),
        .saturated (sat0)
    );

    unary_multi_adder #(.N_IN(N_IN), .U_BITS(U_BITS), .SAT_EN(1'b1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in        (in_v),
        .out       (out1),
        .busy      (busy1),
        .done      (done1),
        .count     (count1),
        .saturated (sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Channel c carries ones on op-relative cycles [op_s[c], op_s[c]+op_l[c]).
    function automatic logic [N_IN-1:0] vec_at(input int unsigned t);
        logic [N_IN-1:0] v;
        v = '0;
        for (int c = 0; c < int'(N_IN); c++) begin
            v[c] = (t >= op_s[c]) && (t < op_s[c] + op_l[c]);
        end
        return v;
    endfunction

    task automatic set_op(input int unsigned l0, input int unsigned l1, input int unsigned l2,
                          input int unsigned l3, input int unsigned s1);
        op_l[0] = l0; op_l[1] = l1; op_l[2] = l2; op_l[3] = l3;
        op_s[0] = 0;  op_s[1] = s1; op_s[2] = 0;  op_s[3] = 0;
    endtask

    // Stimulus always keeps at least one channel active from cycle 0 until the last arrival,
    // so the plain sum burst is T ones on cycles 0..T-1 and done lands on cycle T. With the
    // clamp, T > U_BITS gives U_BITS ones and done on the first quiet cycle at or after U_BITS.
    task automatic run_op(input int unsigned gap);
        int unsigned total;
        int unsigned last_end;
        int unsigned start;
        exp_t        e;
        total    = 0;
        last_end = 0;
        for (int c = 0; c < int'(N_IN); c++) begin
            total += op_l[c];
            if (op_l[c] != 0 && op_s[c] + op_l[c] > last_end) last_end = op_s[c] + op_l[c];
        end
        for (int t = 0; t <= int'(total + gap); t++) begin
            @(posedge clk);
            #1;
            if (t == 0) begin
                start = cyc;
                e.cyc = start + total;
                e.cnt = total;
                e.sat = 0;
                q0.push_back(e);
                if (total > U_BITS) begin
                    e.cyc = start + ((last_end > U_BITS) ? last_end : U_BITS);
                    e.cnt = U_BITS;
                    e.sat = 1;
                end
                q1.push_back(e);
            end
            in_v = vec_at(t);
        end
    endtask

    // Monitor: counts out ones and checks each done pulse against the queued expectation.
    always @(negedge clk) begin
        exp_t e0;
        exp_t e1;
        if (reset) begin
            ones0 = 0;
            ones1 = 0;
        end else begin
            if (out0) ones0++;
            if (out1) ones1++;
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL plain_unexpected_done: got done at cycle %0d, none required",
                             cyc);
                end else begin
                    e0 = q0.pop_front();
                    chk("plain_done_cycle", int'(cyc), int'(e0.cyc));
                    chk("plain_count", int'(count0), int'(e0.cnt));
                    chk("plain_out_ones", int'(ones0), int'(e0.cnt));
                    chk("plain_saturated", int'(sat0), int'(e0.sat));
                    chk("plain_busy_at_done", int'(busy0), 1);
                end
                ones0 = 0;
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL clamp_unexpected_done: got done at cycle %0d, none required",
                             cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("clamp_done_cycle", int'(cyc), int'(e1.cyc));
                    chk("clamp_count", int'(count1), int'(e1.cnt));
                    chk("clamp_out_ones", int'(ones1), int'(e1.cnt));
                    chk("clamp_saturated", int'(sat1), int'(e1.sat));
                    chk("clamp_busy_at_done", int'(busy1), 1);
                end
                ones1 = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_v  = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_out_plain", int'(out0), 0);
            chk("rst_out_clamp", int'(out1), 0);
            chk("rst_done_plain", int'(done0), 0);
            chk("rst_done_clamp", int'(done1), 0);
        end
        chk("rst_busy_plain", int'(busy0), 0);
        chk("rst_busy_clamp", int'(busy1), 0);
        chk("rst_count_plain", int'(count0), 0);
        chk("rst_count_clamp", int'(count1), 0);
        chk("rst_sat_plain", int'(sat0), 0);
        chk("rst_sat_clamp", int'(sat1), 0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        in_v  = '0;
        @(negedge clk);
        chk("idle_out", int'(out0), 0);
        chk("idle_done", int'(done1), 0);
        chk("idle_busy", int'(busy1), 0);

        set_op(3, 5, 0, 2, 0);  run_op(2);
        set_op(8, 8, 8, 8, 0);  run_op(1);
        set_op(8, 8, 0, 0, 0);  run_op(1);
        set_op(4, 3, 0, 0, 2);  run_op(2);
        set_op(2, 2, 0, 0, 0);  run_op(0);
        set_op(1, 0, 0, 0, 0);  run_op(2);
        set_op(16, 16, 16, 16, 0); run_op(0);
        set_op(16, 0, 0, 1, 0); run_op(3);

        // Reset in the middle of a 5+5 operation abandons it without a done pulse.
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            in_v  = (t <= 3) ? N_IN'(3) : N_IN'(0);
            reset = (t == 3);
            @(negedge clk);
            if (t == 3) begin
                chk("midrst_out_plain", int'(out0), 0);
                chk("midrst_out_clamp", int'(out1), 0);
                chk("midrst_done_plain", int'(done0), 0);
            end
            if (t >= 4) begin
                chk("midrst_busy_plain", int'(busy0), 0);
                chk("midrst_busy_clamp", int'(busy1), 0);
                chk("midrst_count_plain", int'(count0), 0);
                chk("midrst_count_clamp", int'(count1), 0);
                chk("midrst_out_after", int'(out1), 0);
            end
        end

        for (int k = 0; k < int'(N_RAND); k++) begin
            op_s[0] = 0;
            op_l[0] = $urandom_range(U_BITS, 3);
            for (int c = 1; c < int'(N_IN); c++) begin
                op_s[c] = $urandom_range(2, 0);
                op_l[c] = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(U_BITS, 1);
            end
            run_op($urandom_range(2, 0));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("plain_unserved_ops", q0.size(), 0);
        chk("clamp_unserved_ops", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unary_multi_adder.md
UNARY_MULTI_ADDER -- requirements
Module: unary_multi_adder

Interface
REQ-001 Parameter N_IN, default 4, number of unary input channels; SHALL be >= 2.
REQ-002 Parameter U_BITS, default 16, maximum legal burst length per input channel and the output clamp length.
REQ-003 Parameter SAT_EN, default 0; 1 SHALL clamp output burst length to U_BITS, 0 SHALL emit the full sum.
REQ-004 Derived CNT_W = clog2(N_IN*U_BITS+1), width of all internal and output counters.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in  input  N_IN  unary input bursts, one bit per channel.
REQ-008 out  output  1  unary sum burst.
REQ-009 busy  output  1  high while state is RUN or SAT.
REQ-010 done  output  1  one-cycle pulse marking end of an operation.
REQ-011 count  output  CNT_W  number of out ones emitted in the current or most recent operation.
REQ-012 saturated  output  1  sticky flag: ones were discarded in the current or most recent operation.

Function
REQ-013 State machine SHALL have states IDLE, RUN, SAT; reset state IDLE.
REQ-014 pop = popcount(in), computed combinationally, CNT_W bits.
REQ-015 IDLE: out = |in; if |in, next state RUN, pending <= pop-1, count <= 1, saturated <= 0.
REQ-016 IDLE with in == 0: out = 0, no register changes, done = 0.
REQ-017 RUN: out = |in OR (pending != 0), zero latency (combinational from in and state).
REQ-018 RUN: pending <= pending + pop - out; count <= count + out.
REQ-019 RUN with out == 0: done = 1 that cycle, next state IDLE; count and saturated hold.
REQ-020 Ones arriving on any channel while in RUN SHALL be accumulated into the current operation.
REQ-021 SAT_EN = 1: when a cycle with out = 1 makes count reach U_BITS, next state SAT, pending <= 0; saturated <= 1 if pending + pop - 1 != 0 or any channel still high next cycle.
REQ-022 SAT: out = 0; inputs discarded; any in bit high sets saturated; when in == 0, done = 1 that cycle, next state IDLE.
REQ-023 Sum exactly U_BITS with SAT_EN = 1: output U_BITS ones, saturated stays 0.
REQ-024 SAT_EN = 0: SAT state unreachable; output length equals total input ones.
REQ-025 Pending overflow (protocol violation, channel longer than U_BITS): pending SHALL stick at all-ones and saturated SHALL be set.
REQ-026 New operation MAY start in the cycle immediately after done; count and saturated reinitialise per REQ-015.
REQ-027 done SHALL never assert in IDLE; busy = (state != IDLE), registered.

Reset
REQ-028 While reset is high: out = 0, done = 0, busy = 0, count = 0, saturated = 0, pending = 0, state IDLE.
REQ-029 Reset mid-operation SHALL abandon the operation; no done pulse; first cycle after reset deassertion behaves as IDLE.
REQ-030 Input bits high during reset SHALL be ignored.

Verification
REQ-031 SAT_EN=0, N_IN=4: channels 3,5,0,2 ones from cycle 0 -> out high cycles 0-9, done cycle 10, count=10, saturated=0.
REQ-032 SAT_EN=1: all 4 channels 8 ones from cycle 0 -> out high cycles 0-15, SAT cycle 16 with in=0, done cycle 16, count=16, saturated=1.
REQ-033 SAT_EN=1: channels 8,8,0,0 -> out high cycles 0-15, done cycle 16, count=16, saturated=0.
REQ-034 Staggered: ch0 4 ones from cycle 0, ch1 3 ones from cycle 2 -> out high cycles 0-6, done cycle 7, count=7.
REQ-035 Back-to-back: op A (2+2) done cycle 4, op B (1+0) starts cycle 5 -> count=1 in cycle 6, done cycle 6, saturated=0.
REQ-036 Reset asserted cycle 3 of a 5+5 op for one cycle, inputs then zero -> out 0 from cycle 3, busy 0 from cycle 4, no done, count 0.
